fanin_rr_flag_ctrl: RTL and testbench
=====================================

# fanin_rr_flag_ctrl

Sequential priority controller for a binary arbitration tree of 2-input round-robin fan-in request primitives. It generates the per-level `RR_FLAG` vector that steers every tree node. The pointer advances on each accepted transfer at the tree root. A per-master starvation watchdog can force the pointer onto a waiting master until that master is granted. One instance sits beside each slave-side arbitration tree in the low-latency interconnect.

## Interface

Parameters:

- `N_MASTER`, 8: number of tree leaves; power of 2, ≥ 2.
- `LOG_MASTER`, $clog2(N_MASTER): tree depth and `RR_FLAG_o` width.
- `MAX_WAIT`, 16: stalled-request cycles that trigger starvation handling; range 1..255.
- `CNT_WIDTH`, 8: width of the per-master wait counters.

Ports (clock and reset first):

- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `req_i`, in, N_MASTER: per-master request (leaf `data_req`).
- `gnt_i`, in, N_MASTER: per-master grant (leaf `data_gnt`).
- `data_req_i`, in, 1: tree root request.
- `data_gnt_i`, in, 1: tree root grant from the slave.
- `lock_i`, in, 1: atomic/burst hold. Freezes the pointer and the FSM.
- `RR_FLAG_o`, out, LOG_MASTER: priority vector. Bit k drives every node at tree level k; level 0 is adjacent to the masters.
- `starve_o`, out, 1: high while the FSM is in STARVE.
- `starve_id_o`, out, LOG_MASTER: index of the master being forced.
- `starve_cnt_o`, out, 16: saturating count of STARVE entries.

## Operation

- **Tree mapping.**
  - Node j at level 0 merges masters 2j (ch0) and 2j+1 (ch1).
  - Flag = 1 favours ch1.
  - Hence `RR_FLAG_o == m` guarantees master m wins whenever it requests.
- **Accept:** `acc = data_req_i & data_gnt_i`.
- **Wait counters,** one per master m, updated every cycle regardless of FSM or lock:
  - `req_i[m] & ~gnt_i[m]` → increment, saturating at MAX_WAIT.
  - Otherwise → 0.
- **Victim:** the lowest index m with `cnt[m] == MAX_WAIT`.
- **FSM state RR:**
  - `lock_i` = 1: pointer and state hold.
  - Else if any victim exists: go to STARVE.
    - Pointer is loaded with the victim; `starve_id_o` is loaded with the victim.
    - `starve_cnt_o` increments, saturating at 0xFFFF.
    - Starvation takes precedence over an `acc` in the same cycle.
  - Else if `acc`: pointer ← (pointer + 1) mod N_MASTER. Wraps from N_MASTER-1 to 0.
- **FSM state STARVE:**
  - `lock_i` = 1: hold.
  - Else if `gnt_i[starve_id]`, or `~req_i[starve_id]` (request withdrawn): go to RR, pointer ← (starve_id + 1) mod N_MASTER.
  - Otherwise hold. Other victims wait; their counters stay saturated.
- **Outputs:**
  - `RR_FLAG_o` = pointer register.
  - `starve_o` = (state == STARVE).
- **Spurious grant:** a `gnt_i[m]` without `req_i[m]` only clears that master's counter.

## Timing

- **Reset values:**
  - `RR_FLAG_o` = 0, `starve_o` = 0, `starve_id_o` = 0, `starve_cnt_o` = 0.
  - All wait counters = 0; state = RR.
- **Reset mid-operation:** reset in any state returns everything to the reset values on the next edge. Reset overrides all inputs.
- **Pointer latency:** all outputs are registered. The pointer changes on the edge after an `acc` cycle, so the next request sees the new priority. There is no combinational path from inputs to outputs.
- **Starvation latency:**
  - A master stalled on cycles 1..MAX_WAIT has `cnt == MAX_WAIT` after edge MAX_WAIT.
  - STARVE and the forced `RR_FLAG_o` are visible after edge MAX_WAIT+1, provided `lock_i` is low.
- **Exit latency:** one cycle after the victim's grant, `starve_o` is 0 and `RR_FLAG_o` = victim+1.
- **Lock release:** `lock_i` falling resumes normal evaluation in the same cycle. Pending `acc` or victim conditions are acted on at that edge.

## Test plan

N_MASTER=4, MAX_WAIT=4 unless stated.

- **Rotation and wrap:** after reset, `data_req_i`=1 and `data_gnt_i`=1 for 5 cycles → `RR_FLAG_o` sequence 0,1,2,3,0. With `data_gnt_i`=0 the pointer holds.
- **Starvation entry:** `req_i`=0100, `gnt_i`=0000 for 4 cycles → after edge 5, `starve_o`=1, `starve_id_o`=2, `RR_FLAG_o`=2, `starve_cnt_o`=1. Then `gnt_i`=0100 → next cycle `starve_o`=0, `RR_FLAG_o`=3, `cnt[2]`=0.
- **Simultaneous victims:** masters 1 and 3 stall together for 4 cycles.
  - Required: victim 1 is forced first.
  - Grant 1 → RR, then STARVE for victim 3 on the following edge.
  - `starve_cnt_o`=2.
- **Lock:** `lock_i`=1 with `acc` every cycle for 6 cycles, while master 0 stalls.
  - Required during lock: `RR_FLAG_o` constant, `starve_o`=0.
  - On release: STARVE with id 0 at the next edge.
- **Withdrawal:** in STARVE with id 3, drop `req_i[3]` → RR, `RR_FLAG_o`=0 next cycle.
- **Reset mid-STARVE:** assert `rst` for 1 cycle → all outputs return to their reset values and the counters clear. Afterwards, rotation restarts from 0.

Source files
------------

// File: rtl/fanin_rr_flag_ctrl.sv
// -----------------------------------------------------------------------------
// fanin_rr_flag_ctrl
//
// Priority controller for a binary tree of 2-input round-robin fan-in nodes.
// It produces the per-level RR_FLAG vector that steers every node so that the
// master whose index equals RR_FLAG_o always wins when it requests.
//
// The pointer advances on every accepted transfer at the tree root. A
// per-master wait counter detects masters stalled for MAX_WAIT cycles. The
// FSM then forces the pointer onto the lowest-index starving master until
// that master is granted or withdraws its request.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_i, gnt_i   per-master leaf request / grant
//   data_req_i     tree root request
//   data_gnt_i     tree root grant from the slave
//   lock_i         atomic/burst hold: freezes the pointer and the FSM
//   RR_FLAG_o      priority vector, bit k steers tree level k
//   starve_o       high while a starving master is being forced
//   starve_id_o    index of the forced master
//   starve_cnt_o   saturating count of starvation entries
// -----------------------------------------------------------------------------
module fanin_rr_flag_ctrl #(
  parameter int N_MASTER   = 8,
  parameter int LOG_MASTER = $clog2(N_MASTER),
  parameter int MAX_WAIT   = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_MASTER-1:0]   req_i,
  input  logic [N_MASTER-1:0]   gnt_i,
  input  logic                  data_req_i,
  input  logic                  data_gnt_i,
  input  logic                  lock_i,
  output logic [LOG_MASTER-1:0] RR_FLAG_o,
  output logic                  starve_o,
  output logic [LOG_MASTER-1:0] starve_id_o,
  output logic [15:0]           starve_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WAIT);

  typedef enum logic {
    S_RR     = 1'b0,
    S_STARVE = 1'b1
  } state_t;

  state_t                state;
  logic [LOG_MASTER-1:0] ptr;
  logic [LOG_MASTER-1:0] starve_id;
  logic [15:0]           starve_cnt;
  logic [CNT_WIDTH-1:0]  wait_cnt [N_MASTER];

  logic                  victim_vld;
  logic [LOG_MASTER-1:0] victim_id;
  logic                  acc;

  function automatic logic [CNT_WIDTH-1:0] wait_inc(input logic [CNT_WIDTH-1:0] c);
    return (c >= MAX_CNT) ? MAX_CNT : c + CNT_WIDTH'(1);
  endfunction

  function automatic logic [15:0] entry_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'(1);
  endfunction

  assign acc = data_req_i & data_gnt_i;

  // Lowest saturated counter wins: scan from the top so the lowest index
  // overwrites any higher one.
  always_comb begin
    victim_vld = 1'b0;
    victim_id  = '0;
    for (int m = N_MASTER - 1; m >= 0; m--) begin
      if (wait_cnt[m] == MAX_CNT) begin
        victim_vld = 1'b1;
        victim_id  = LOG_MASTER'(m);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RR;
      ptr        <= '0;
      starve_id  <= '0;
      starve_cnt <= '0;
      for (int m = 0; m < N_MASTER; m++) begin
        wait_cnt[m] <= '0;
      end
    end else begin
      // Wait counters track stalls independently of the FSM and of lock_i;
      // a grant, even without a request, clears the counter.
      for (int m = 0; m < N_MASTER; m++) begin
        wait_cnt[m] <= (req_i[m] && !gnt_i[m]) ? wait_inc(wait_cnt[m]) : '0;
      end

      if (!lock_i) begin
        case (state)
          S_RR: begin
            // Starvation takes precedence over a root accept in the same cycle.
            if (victim_vld) begin
              state      <= S_STARVE;
              ptr        <= victim_id;
              starve_id  <= victim_id;
              starve_cnt <= entry_inc(starve_cnt);
            end else if (acc) begin
              ptr <= ptr + LOG_MASTER'(1);
            end
          end
          S_STARVE: begin
            // Leave once the victim is served or gives up; resume rotation
            // just past it. Other saturated masters are picked up from RR.
            if (gnt_i[starve_id] || !req_i[starve_id]) begin
              state <= S_RR;
              ptr   <= starve_id + LOG_MASTER'(1);
            end
          end
          default: state <= S_RR;
        endcase
      end
    end
  end

  assign RR_FLAG_o    = ptr;
  assign starve_o     = (state == S_STARVE);
  assign starve_id_o  = starve_id;
  assign starve_cnt_o = starve_cnt;

endmodule

// File: tb/tb_fanin_rr_flag_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for fanin_rr_flag_ctrl (N_MASTER=4, MAX_WAIT=4).
// Directed vector table for the documented scenarios, followed by random
// traffic compared against a behavioural model built from the rules.
// -----------------------------------------------------------------------------
module tb_fanin_rr_flag_ctrl;

  localparam int N  = 4;
  localparam int LG = 2;
  localparam int MW = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          dreq;
  logic          dgnt;
  logic          lock;
  logic [LG-1:0] rr_flag;
  logic          starve;
  logic [LG-1:0] starve_id;
  logic [15:0]   starve_cnt;

  fanin_rr_flag_ctrl #(
    .N_MASTER  (N),
    .LOG_MASTER(LG),
    .MAX_WAIT  (MW),
    .CNT_WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .gnt_i       (gnt),
    .data_req_i  (dreq),
    .data_gnt_i  (dgnt),
    .lock_i      (lock),
    .RR_FLAG_o   (rr_flag),
    .starve_o    (starve),
    .starve_id_o (starve_id),
    .starve_cnt_o(starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs are the values seen just after the edge that samples
  // the record's inputs.
  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          dreq;
    logic          dgnt;
    logic          lock;
    logic [LG-1:0] flag;
    logic          st;
    logic [LG-1:0] id;
    logic [15:0]   scnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic [N-1:0] rq, logic [N-1:0] gn,
                              logic dr, logic dg, logic lk,
                              logic [LG-1:0] fl, logic s, logic [LG-1:0] i,
                              logic [15:0] sc);
    vec_t v;
    v.rst = r; v.req = rq; v.gnt = gn; v.dreq = dr; v.dgnt = dg; v.lock = lk;
    v.flag = fl; v.st = s; v.id = i; v.scnt = sc;
    return v;
  endfunction

  // Behavioural model: plain integers, state as a "currently forcing" flag.
  int m_cnt [N];
  bit m_forcing;
  int m_ptr, m_sid, m_scnt;

  task automatic model_step(input logic r, input logic [N-1:0] rq,
                            input logic [N-1:0] gn, input logic dr,
                            input logic dg, input logic lk);
    int victim;
    if (r) begin
      for (int m = 0; m < N; m++) m_cnt[m] = 0;
      m_forcing = 0; m_ptr = 0; m_sid = 0; m_scnt = 0;
      return;
    end
    victim = -1;
    for (int m = 0; m < N; m++)
      if (victim < 0 && m_cnt[m] == MW) victim = m;
    if (!lk) begin
      if (!m_forcing) begin
        if (victim >= 0) begin
          m_forcing = 1;
          m_ptr = victim;
          m_sid = victim;
          if (m_scnt < 65535) m_scnt = m_scnt + 1;
        end else if (dr && dg) begin
          m_ptr = (m_ptr + 1) % N;
        end
      end else if (gn[m_sid] || !rq[m_sid]) begin
        m_forcing = 0;
        m_ptr = (m_sid + 1) % N;
      end
    end
    for (int m = 0; m < N; m++)
      m_cnt[m] = (rq[m] && !gn[m]) ? ((m_cnt[m] + 1 > MW) ? MW : m_cnt[m] + 1) : 0;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [N-1:0] rq, input logic [N-1:0] gn,
                       input logic dr, input logic dg, input logic lk);
    rst = r; req = rq; gnt = gn; dreq = dr; dgnt = dg; lock = lk;
    @(posedge clk);
    #1;
    model_step(r, rq, gn, dr, dg, lk);
  endtask

  initial begin
    rst = 1'b1; req = '0; gnt = '0; dreq = 1'b0; dgnt = 1'b0; lock = 1'b0;

    // Reset
    vq.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    // Rotation and wrap, then hold without root grant
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 0, 2, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 0, 3, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 1, 0, 0, 0));
    // Starvation entry for master 2, then grant
    vq.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 0, 2, 1, 2, 1));
    vq.push_back(mk(0, 4'b0100, 4'b0100, 0, 0, 0, 3, 0, 2, 1));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 3, 0, 2, 1));
    // Simultaneous victims 1 and 3, then withdrawal of 3
    vq.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0, 4'b1010, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b1010, 4'b0000, 0, 0, 0, 1, 1, 1, 1));
    vq.push_back(mk(0, 4'b1010, 4'b0010, 0, 0, 0, 2, 0, 1, 1));
    vq.push_back(mk(0, 4'b1010, 4'b0000, 0, 0, 0, 3, 1, 3, 2));
    vq.push_back(mk(0, 4'b0010, 4'b0000, 0, 0, 0, 0, 0, 3, 2));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 3, 2));
    // Lock with accepts while master 0 stalls, release, reset mid-STARVE
    vq.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++)
      vq.push_back(mk(0, 4'b0001, 4'b0000, 1, 1, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0001, 4'b0000, 1, 1, 0, 0, 1, 0, 1));
    vq.push_back(mk(1, 4'b0001, 4'b0000, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 0, 2, 0, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      cycle(vq[i].rst, vq[i].req, vq[i].gnt, vq[i].dreq, vq[i].dgnt, vq[i].lock);
      check($sformatf("vec%0d_flag", i), int'(rr_flag), int'(vq[i].flag));
      check($sformatf("vec%0d_starve", i), int'(starve), int'(vq[i].st));
      check($sformatf("vec%0d_id", i), int'(starve_id), int'(vq[i].id));
      check($sformatf("vec%0d_scnt", i), int'(starve_cnt), int'(vq[i].scnt));
    end

    // Random traffic against the model; grants are sparse so stalls build up.
    cycle(1, '0, '0, 0, 0, 0);
    for (int t = 0; t < 3000; t++) begin
      logic [N-1:0] rq, gn;
      logic r, dr, dg, lk;
      rq = N'($urandom);
      gn = '0;
      for (int m = 0; m < N; m++)
        if ($urandom_range(0, 3) == 0) gn[m] = 1'b1;
      if ($urandom_range(0, 7) != 0) gn = gn & rq;
      dr = |rq;
      dg = ($urandom_range(0, 1) == 1);
      lk = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 499) == 0);
      cycle(r, rq, gn, dr, dg, lk);
      check("rnd_flag", int'(rr_flag), m_ptr);
      check("rnd_starve", int'(starve), int'(m_forcing));
      check("rnd_id", int'(starve_id), m_sid);
      check("rnd_scnt", int'(starve_cnt), m_scnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
